sig_sync_filt: RTL and testbench
================================

SIG_SYNC_FILT -- requirements
Module: sig_sync_filt

Interface
REQ-001 SHALL have parameter SIG_WTH, default 1: number of independent single-bit channels.
REQ-002 SHALL have parameter SIG_DLY, default 2: synchroniser flop stages per channel; legal range is 2 and up.
REQ-003 SHALL have parameter FLT_CNT, default 4: consecutive stable cycles required to accept a new level; legal range is 1 and up.
REQ-004 SHALL have parameter RST_VAL, default all-zero, SIG_WTH bits: per-channel reset level.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port data_i, input, SIG_WTH bits: asynchronous channel inputs.
REQ-008 SHALL have port clr_i, input, SIG_WTH bits: per-channel clear for chg_o.
REQ-009 SHALL have port data_o, output, SIG_WTH bits: synchronised, filtered level.
REQ-010 SHALL have port rise_o, output, SIG_WTH bits: one-cycle pulse when data_o goes 0->1.
REQ-011 SHALL have port fall_o, output, SIG_WTH bits: one-cycle pulse when data_o goes 1->0.
REQ-012 SHALL have port chg_o, output, SIG_WTH bits: sticky flag meaning an edge was accepted since the last clear.

Function
REQ-013 Each channel SHALL be fully independent, with no cross-channel logic.
REQ-014 Each channel SHALL pass data_i through a SIG_DLY-stage shift chain; the last stage is sync_q.
REQ-015 Each channel SHALL hold a filtered state flt (driving data_o) and a counter cnt of width $clog2(FLT_CNT+1).
REQ-016 On each clock with sync_q equal to flt, cnt SHALL be set to 0.
REQ-017 On each clock with sync_q not equal to flt and cnt below FLT_CNT-1, cnt SHALL increment by 1.
REQ-018 On each clock with sync_q not equal to flt and cnt equal to FLT_CNT-1, flt SHALL take sync_q and cnt SHALL be set to 0.
REQ-019 With FLT_CNT=1, flt SHALL follow sync_q with one register of delay and no filtering.
REQ-020 A data_i level held steady SHALL appear on data_o exactly SIG_DLY+FLT_CNT rising edges after the first edge that samples it.
REQ-021 A mismatch lasting fewer than FLT_CNT consecutive sync_q cycles SHALL leave data_o unchanged and SHALL NOT assert rise_o or fall_o.
REQ-022 cnt SHALL never exceed FLT_CNT-1 and SHALL never wrap.
REQ-023 rise_o and fall_o SHALL be registered and asserted in the same cycle data_o takes its new value, for exactly one cycle.
REQ-024 rise_o and fall_o SHALL never be high together on the same channel.
REQ-025 chg_o SHALL set on the cycle after rise_o or fall_o would be computed, i.e. it is visible one cycle after the pulse.
REQ-026 chg_o SHALL clear when clr_i is high and remain clear until the next accepted edge.
REQ-027 If clr_i is high on the same clock an edge is accepted, set SHALL win and chg_o SHALL read 1.
REQ-028 clr_i SHALL have no effect on data_o, cnt, rise_o or fall_o.

Reset
REQ-029 While rst_i is high at a clock edge, all sync stages and flt SHALL load RST_VAL.
REQ-030 While rst_i is high at a clock edge, cnt, rise_o, fall_o and chg_o SHALL load 0.
REQ-031 Reset asserted mid-count SHALL discard the partial count.
REQ-032 Leaving reset SHALL generate no edge pulse, even if data_i differs from RST_VAL; such a difference is filtered normally afterwards.
REQ-033 The block SHALL have no asynchronous reset path.

Verification
REQ-034 The bench SHALL cover latency: SIG_WTH=4, SIG_DLY=2, FLT_CNT=3, RST_VAL=0; data_i goes 0000->0001 before edge E1 -> data_o=0001 and rise_o=0001 at E5 only; chg_o=0001 from E6.
REQ-035 The bench SHALL cover glitch rejection: same config; data_i[1] high for 2 cycles then low -> data_o[1] stays 0; rise_o and fall_o stay 0; cnt returns to 0.
REQ-036 The bench SHALL cover the fall edge with RST_VAL=1111: after reset data_i=1111; bit 3 drops -> fall_o=1000 for one cycle; data_o=0111.
REQ-037 The bench SHALL cover clear/set collision: clr_i[0]=1 on the rise_o[0] set cycle -> chg_o[0]=1; clr_i[0]=1 on the next cycle -> chg_o[0]=0.
REQ-038 The bench SHALL cover reset mid-count: mismatch for 2 cycles, then rst_i=1 for 1 cycle -> all outputs equal reset values; no pulses after release until a full SIG_DLY+FLT_CNT qualification.
REQ-039 The bench SHALL cover FLT_CNT=1: a 1-cycle data_i pulse -> a 1-cycle data_o pulse, with rise_o and fall_o on consecutive cycles.

Source files
------------

// File: rtl/sig_sync_filt.sv
// rtl/sig_sync_filt.sv - per-channel synchroniser with stability filter and edge/change flags
module sig_sync_filt #(
  parameter int                 SIG_WTH = 1,
  parameter int                 SIG_DLY = 2,
  parameter int                 FLT_CNT = 4,
  parameter logic [SIG_WTH-1:0] RST_VAL = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SIG_WTH-1:0] data_i,
  input  logic [SIG_WTH-1:0] clr_i,
  output logic [SIG_WTH-1:0] data_o,
  output logic [SIG_WTH-1:0] rise_o,
  output logic [SIG_WTH-1:0] fall_o,
  output logic [SIG_WTH-1:0] chg_o
);

  localparam int               CNT_W   = $clog2(FLT_CNT + 1);
  // Terminal count: a mismatch seen while the counter sits here is the
  // FLT_CNT-th consecutive one, so the new level is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLT_CNT - 1);

  // Synchroniser chain, all channels side by side; stage SIG_DLY-1 is sync_q.
  logic [SIG_WTH-1:0] sync_q [SIG_DLY];
  logic [SIG_WTH-1:0] sync_last;

  assign sync_last = sync_q[SIG_DLY-1];

  // Shift the asynchronous inputs through the metastability stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SIG_DLY; i++) begin
        sync_q[i] <= RST_VAL;
      end
    end else begin
      sync_q[0] <= data_i;
      for (int i = 1; i < SIG_DLY; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  for (genvar g = 0; g < SIG_WTH; g++) begin : g_ch
    logic             flt_q;
    logic             flt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             acc;
    logic             rise_q;
    logic             fall_q;
    logic             chg_q;

    // Filter decision: count consecutive mismatches, accept on the last one.
    always_comb begin
      cnt_d = cnt_q;
      flt_d = flt_q;
      acc   = 1'b0;
      if (sync_last[g] == flt_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        flt_d = sync_last[g];
        cnt_d = '0;
        acc   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Filter state, edge pulses aligned with the new level, and sticky change flag
    // (a pending pulse beats a simultaneous clear).
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        flt_q  <= RST_VAL[g];
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        chg_q  <= 1'b0;
      end else begin
        flt_q  <= flt_d;
        cnt_q  <= cnt_d;
        rise_q <= acc & flt_d;
        fall_q <= acc & ~flt_d;
        chg_q  <= rise_q | fall_q | (chg_q & ~clr_i[g]);
      end
    end

    assign data_o[g] = flt_q;
    assign rise_o[g] = rise_q;
    assign fall_o[g] = fall_q;
    assign chg_o[g]  = chg_q;
  end

endmodule

// File: tb/tb_sig_sync_filt.sv
// tb/tb_sig_sync_filt.sv - self-checking bench for sig_sync_filt
module tb_sig_sync_filt;

  localparam int         A_DLY = 2;
  localparam int         A_FLT = 3;
  localparam logic [3:0] A_RV  = 4'b0000;

  logic clk;
  int   n_chk = 0;
  int   n_err = 0;

  logic       rst_a, rst_b, rst_c;
  logic [3:0] data_a, clr_a, do_a, rise_a, fall_a, chg_a;
  logic [3:0] data_b, clr_b, do_b, rise_b, fall_b, chg_b;
  logic [3:0] data_c, clr_c, do_c, rise_c, fall_c, chg_c;

  sig_sync_filt #(.SIG_WTH(4), .SIG_DLY(A_DLY), .FLT_CNT(A_FLT), .RST_VAL(A_RV)) u_a (
    .clk_i(clk), .rst_i(rst_a), .data_i(data_a), .clr_i(clr_a),
    .data_o(do_a), .rise_o(rise_a), .fall_o(fall_a), .chg_o(chg_a));

  sig_sync_filt #(.SIG_WTH(4), .SIG_DLY(2), .FLT_CNT(3), .RST_VAL(4'b1111)) u_b (
    .clk_i(clk), .rst_i(rst_b), .data_i(data_b), .clr_i(clr_b),
    .data_o(do_b), .rise_o(rise_b), .fall_o(fall_b), .chg_o(chg_b));

  sig_sync_filt #(.SIG_WTH(4), .SIG_DLY(2), .FLT_CNT(1), .RST_VAL(4'b0000)) u_c (
    .clk_i(clk), .rst_i(rst_c), .data_i(data_c), .clr_i(clr_c),
    .data_o(do_c), .rise_o(rise_c), .fall_o(fall_c), .chg_o(chg_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for u_a: a level is accepted when the last FLT_CNT samples,
  // seen SIG_DLY edges late, all disagree with the current output level.
  logic [3:0] hist [0:16383];
  int         edge_n   = 0;
  int         last_rst = 0;
  logic [3:0] m_flt = A_RV, m_rise = '0, m_fall = '0, m_chg = '0;

  always @(posedge clk) begin
    logic flip;
    logic s;
    int   k;
    edge_n = edge_n + 1;
    hist[edge_n % 16384] = data_a;
    if (rst_a) begin
      m_flt    = A_RV;
      m_rise   = '0;
      m_fall   = '0;
      m_chg    = '0;
      last_rst = edge_n;
    end else begin
      m_chg = m_rise | m_fall | (m_chg & ~clr_a);
      for (int ch = 0; ch < 4; ch++) begin
        flip = 1'b1;
        for (int j = 0; j < A_FLT; j++) begin
          k = edge_n - A_DLY - j;
          s = (k <= last_rst) ? A_RV[ch] : hist[k % 16384][ch];
          if (s == m_flt[ch]) flip = 1'b0;
        end
        m_rise[ch] = flip & ~m_flt[ch];
        m_fall[ch] = flip & m_flt[ch];
        if (flip) m_flt[ch] = ~m_flt[ch];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got data=%h rise=%h fall=%h chg=%h, expected data=%h rise=%h fall=%h chg=%h",
               nm, act[15:12], act[11:8], act[7:4], act[3:0],
               exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] d;
    logic [3:0] clr;
    logic [3:0] e_do;
    logic [3:0] e_r;
    logic [3:0] e_f;
    logic [3:0] e_c;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] d, input logic [3:0] c,
                     input logic [3:0] eo, input logic [3:0] er, input logic [3:0] ef,
                     input logic [3:0] ec);
    vec_t v;
    v.rst = r; v.d = d; v.clr = c; v.e_do = eo; v.e_r = er; v.e_f = ef; v.e_c = ec;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] d;
    logic [3:0] c;
    logic       r;

    rst_a = 1'b1; data_a = '0; clr_a = '0;
    rst_b = 1'b1; data_b = 4'hF; clr_b = '0;
    rst_c = 1'b1; data_c = '0; clr_c = '0;

    // reset, then latency of a single rising channel, clear/set collision
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
    add(0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1);
    add(0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    add(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    // two-cycle glitch on bit 1, then a one-cycle glitch that must also be rejected
    add(0, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(0, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) add(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(0, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) add(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    // falling edge on bit 0, sticky change flag
    for (int i = 0; i < 4; i++) add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1);

    foreach (tbl[i]) begin
      rst_a = tbl[i].rst; data_a = tbl[i].d; clr_a = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d", i), {do_a, rise_a, fall_a, chg_a},
          {tbl[i].e_do, tbl[i].e_r, tbl[i].e_f, tbl[i].e_c});
    end

    // reset in the middle of a count; leaving reset with data_i != RST_VAL
    data_a = 4'b0101;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("midcnt_e%0d", i), {do_a, rise_a, fall_a, chg_a}, {4'h0, 4'h0, 4'h0, 4'h1});
    end
    rst_a = 1'b1;
    tick();
    chk("midcnt_rst", {do_a, rise_a, fall_a, chg_a}, 16'h0000);
    rst_a = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      tick();
      chk($sformatf("midcnt_e%0d", i), {do_a, rise_a, fall_a, chg_a}, 16'h0000);
    end
    tick();
    chk("midcnt_e10", {do_a, rise_a, fall_a, chg_a}, {4'h5, 4'h5, 4'h0, 4'h0});
    tick();
    chk("midcnt_e11", {do_a, rise_a, fall_a, chg_a}, {4'h5, 4'h0, 4'h0, 4'h5});

    // fall edge with an all-ones reset level
    rst_b = 1'b1; data_b = 4'hF;
    tick();
    chk("b_rst", {do_b, rise_b, fall_b, chg_b}, {4'hF, 4'h0, 4'h0, 4'h0});
    rst_b = 1'b0;
    tick();
    chk("b_idle", {do_b, rise_b, fall_b, chg_b}, {4'hF, 4'h0, 4'h0, 4'h0});
    data_b = 4'b0111;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("b_e%0d", i), {do_b, rise_b, fall_b, chg_b}, {4'hF, 4'h0, 4'h0, 4'h0});
    end
    tick();
    chk("b_e5", {do_b, rise_b, fall_b, chg_b}, {4'h7, 4'h0, 4'h8, 4'h0});
    tick();
    chk("b_e6", {do_b, rise_b, fall_b, chg_b}, {4'h7, 4'h0, 4'h0, 4'h8});

    // unfiltered configuration: one-cycle pulse passes straight through
    rst_c = 1'b1; data_c = 4'h0;
    tick();
    chk("c_rst", {do_c, rise_c, fall_c, chg_c}, 16'h0000);
    rst_c = 1'b0;
    tick();
    data_c = 4'h1;
    tick();
    chk("c_e1", {do_c, rise_c, fall_c, chg_c}, 16'h0000);
    data_c = 4'h0;
    tick();
    chk("c_e2", {do_c, rise_c, fall_c, chg_c}, 16'h0000);
    tick();
    chk("c_e3", {do_c, rise_c, fall_c, chg_c}, {4'h1, 4'h1, 4'h0, 4'h0});
    tick();
    chk("c_e4", {do_c, rise_c, fall_c, chg_c}, {4'h0, 4'h0, 4'h1, 4'h1});
    tick();
    chk("c_e5", {do_c, rise_c, fall_c, chg_c}, {4'h0, 4'h0, 4'h0, 4'h1});

    // randomized traffic on u_a against the window model
    d = data_a;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) d[b] = ~d[b];
      end
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      r = ($urandom_range(0, 199) == 0);
      data_a = d; clr_a = c; rst_a = r;
      tick();
      chk($sformatf("rnd%0d", i), {do_a, rise_a, fall_a, chg_a}, {m_flt, m_rise, m_fall, m_chg});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
